// File: rtl/boot_seq_pkg.sv
// -----------------------------------------------------------------------------
// boot_seq_pkg
// Shared types and default constants for the boot/run sequencer.
//   boot_seq_state_e : sequencer FSM states (HOLD..DONE)
//   boot_result_e    : final run result (NONE/PASS/FAIL/TIMEOUT)
//   RESET_WAIT_CYCLES, CNT_W : default parameter values
//   hold_cnt_w()     : width needed to count 0..cycles-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package boot_seq_pkg;

    localparam int unsigned RESET_WAIT_CYCLES = 50;
    localparam int unsigned CNT_W             = 32;

    typedef enum logic [2:0] {
        HOLD,
        SAMPLE,
        LOAD,
        KICK,
        RUN,
        DONE
    } boot_seq_state_e;

    typedef enum logic [1:0] {
        RESULT_NONE,
        RESULT_PASS,
        RESULT_FAIL,
        RESULT_TIMEOUT
    } boot_result_e;

    function automatic int unsigned hold_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (count -> 0)
//   clr    : synchronous clear, has priority over en
//   en     : count enable
//   count  : current count value (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of its inputs.
        if (rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/boot_seq_ctrl.sv
// -----------------------------------------------------------------------------
// boot_seq_ctrl
// Boot and run sequencer between the platform clock/reset and the core domain.
// Holds the core in reset, latches the boot straps, optionally handshakes a
// memory preload and kicks the boot-ROM loop, then supervises the run until an
// exit code arrives or the cycle budget is spent.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   boot_select_i           : strap, 0 = JTAG boot, 1 = flash boot
//   execute_from_flash_i    : strap, memory-mapped flash vs SPI copy
//   jtag_mode_i             : debugger present, skip the preload
//   load_done_i             : preload agent finished
//   max_cycles_i            : run cycle budget, 0 = unlimited
//   exit_valid_i/value_i    : exit strobe and code from the SoC
//   core_rst_no             : active-low core reset
//   boot_select_o, execute_from_flash_o : latched straps
//   load_req_o, exit_loop_o : preload request, boot-ROM release pulse
//   cycle_cnt_o             : saturating cycles since core reset release
//   done_o, pass_o, fail_o, timeout_o, exit_value_o : sticky final status
// -----------------------------------------------------------------------------
module boot_seq_ctrl #(
    parameter int unsigned RESET_WAIT_CYCLES = boot_seq_pkg::RESET_WAIT_CYCLES,
    parameter int unsigned CNT_W             = boot_seq_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             boot_select_i,
    input  logic             execute_from_flash_i,
    input  logic             jtag_mode_i,
    input  logic             load_done_i,
    input  logic [CNT_W-1:0] max_cycles_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             core_rst_no,
    output logic             boot_select_o,
    output logic             execute_from_flash_o,
    output logic             load_req_o,
    output logic             exit_loop_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [31:0]      exit_value_o
);

    import boot_seq_pkg::*;

    localparam int unsigned        HOLD_W    = hold_cnt_w(RESET_WAIT_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_WAIT_CYCLES - 1);

    boot_seq_state_e    state_q, state_d;
    boot_result_e       result_q, result_d;
    logic [31:0]        exit_value_d;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               active;
    logic               budget_hit;

    // States in which the run clock is ticking and an exit is accepted.
    assign active     = (state_q == SAMPLE) || (state_q == LOAD) ||
                        (state_q == KICK)   || (state_q == RUN);
    assign budget_hit = (max_cycles_i != '0) && (cycle_cnt_o >= max_cycles_i);

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (state_q != HOLD),
        .en    (state_q == HOLD),
        .count (hold_cnt)
    );

    // Held at zero through HOLD so the count starts at 0 in SAMPLE; the
    // increment is suppressed on the edge entering DONE so the value seen at
    // the trigger is the value that stays frozen.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (state_q == HOLD),
        .en    (active && (state_d != DONE)),
        .count (cycle_cnt_o)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d      = state_q;
        result_d     = result_q;
        exit_value_d = exit_value_o;

        case (state_q)
            HOLD:    if (hold_cnt == HOLD_LAST) state_d = SAMPLE;
            SAMPLE:  state_d = (!boot_select_i && !jtag_mode_i) ? LOAD : RUN;
            LOAD:    if (load_done_i) state_d = KICK;
            KICK:    state_d = RUN;
            RUN: begin
                if (budget_hit) begin
                    state_d  = DONE;
                    result_d = RESULT_TIMEOUT;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = HOLD;
        endcase

        // Evaluated last so an exit overrides a budget hit in the same cycle.
        if (active && exit_valid_i) begin
            state_d      = DONE;
            result_d     = (exit_value_i == '0) ? RESULT_PASS : RESULT_FAIL;
            exit_value_d = exit_value_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            core_rst_no          <= 1'b0;
            load_req_o           <= 1'b0;
            exit_loop_o          <= 1'b0;
            done_o               <= 1'b0;
            result_q             <= RESULT_NONE;
            exit_value_o         <= '0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
        end else begin
            core_rst_no  <= (state_d != HOLD);
            load_req_o   <= (state_d == LOAD);
            exit_loop_o  <= (state_d == KICK);
            done_o       <= (state_d == DONE);
            result_q     <= result_d;
            exit_value_o <= exit_value_d;
            if (state_q == SAMPLE) begin
                boot_select_o        <= boot_select_i;
                execute_from_flash_o <= execute_from_flash_i & boot_select_i;
            end
        end
    end

    assign pass_o    = (result_q == RESULT_PASS);
    assign fail_o    = (result_q == RESULT_FAIL);
    assign timeout_o = (result_q == RESULT_TIMEOUT);

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_seq_ctrl
// Directed bench for boot_seq_ctrl. Main instance uses the default 50-cycle
// hold and 32-bit counter; a second small instance (4-bit counter, 4-cycle
// hold) exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_boot_seq_ctrl;

    localparam int unsigned RWC = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst = 1'b1;
    logic        boot_select = 1'b0;
    logic        exec_flash = 1'b0;
    logic        jtag_mode = 1'b0;
    logic        load_done = 1'b0;
    logic [31:0] max_cycles = '0;
    logic        exit_valid = 1'b0;
    logic [31:0] exit_value = '0;
    logic        core_rst_n;
    logic        boot_select_q;
    logic        exec_flash_q;
    logic        load_req;
    logic        exit_loop;
    logic [31:0] cycle_cnt;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] exit_value_q;

    // Small instance signals
    logic        s_rst = 1'b1;
    logic        s_core_rst_n;
    logic        s_boot_select_q;
    logic        s_exec_flash_q;
    logic        s_load_req;
    logic        s_exit_loop;
    logic [3:0]  s_cycle_cnt;
    logic        s_done;
    logic        s_pass;
    logic        s_fail;
    logic        s_timeout;
    logic [31:0] s_exit_value_q;

    int n_checks = 0;
    int n_errors = 0;
    int hi;

    boot_seq_ctrl #(.RESET_WAIT_CYCLES(RWC), .CNT_W(32)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .boot_select_i        (boot_select),
        .execute_from_flash_i (exec_flash),
        .jtag_mode_i          (jtag_mode),
        .load_done_i          (load_done),
        .max_cycles_i         (max_cycles),
        .exit_valid_i         (exit_valid),
        .exit_value_i         (exit_value),
        .core_rst_no          (core_rst_n),
        .boot_select_o        (boot_select_q),
        .execute_from_flash_o (exec_flash_q),
        .load_req_o           (load_req),
        .exit_loop_o          (exit_loop),
        .cycle_cnt_o          (cycle_cnt),
        .done_o               (done),
        .pass_o               (pass),
        .fail_o               (fail),
        .timeout_o            (timeout),
        .exit_value_o         (exit_value_q)
    );

    boot_seq_ctrl #(.RESET_WAIT_CYCLES(4), .CNT_W(4)) dut_s (
        .clk_i                (clk),
        .rst_i                (s_rst),
        .boot_select_i        (1'b1),
        .execute_from_flash_i (1'b0),
        .jtag_mode_i          (1'b0),
        .load_done_i          (1'b0),
        .max_cycles_i         (4'd0),
        .exit_valid_i         (1'b0),
        .exit_value_i         (32'd0),
        .core_rst_no          (s_core_rst_n),
        .boot_select_o        (s_boot_select_q),
        .execute_from_flash_o (s_exec_flash_q),
        .load_req_o           (s_load_req),
        .exit_loop_o          (s_exit_loop),
        .cycle_cnt_o          (s_cycle_cnt),
        .done_o               (s_done),
        .pass_o               (s_pass),
        .fail_o               (s_fail),
        .timeout_o            (s_timeout),
        .exit_value_o         (s_exit_value_q)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- Reset values ----------------
        #2;
        chk1 ("rst_core_rst_no", core_rst_n, 1'b0);
        chk1 ("rst_load_req",    load_req,   1'b0);
        chk1 ("rst_done",        done,       1'b0);
        chk32("rst_cycle_cnt",   cycle_cnt,  32'd0);
        chk1 ("s_rst_core_rst_no", s_core_rst_n, 1'b0);
        chk32("s_rst_cycle_cnt",   32'(s_cycle_cnt), 32'd0);

        // ---------------- Test 1: JTAG boot with preload ----------------
        rst = 1'b0;                       // deasserted between edges
        step(RWC - 1);                    // edge 49
        chk1 ("t1_hold_edge49", core_rst_n, 1'b0);
        step(1);                          // edge 50: SAMPLE
        chk1 ("t1_release_edge50", core_rst_n, 1'b1);
        chk1 ("t1_sample_no_req",  load_req,   1'b0);
        chk32("t1_sample_cnt",     cycle_cnt,  32'd0);
        step(1);                          // edge 51: LOAD
        chk1 ("t1_load_req_rise",  load_req,   1'b1);
        chk1 ("t1_bootsel_latch",  boot_select_q, 1'b0);
        chk32("t1_load_cnt",       cycle_cnt,  32'd1);
        hi = 1;
        for (int i = 1; i <= 20; i++) begin
            step(1);                      // edges 52..71
            if (load_req) hi++;
            if (i == 20) load_done = 1'b1;
        end
        chk1 ("t1_no_kick_yet", exit_loop, 1'b0);
        step(1);                          // edge 72: KICK
        if (load_req) hi++;
        load_done = 1'b0;
        chk32("t1_load_req_len", 32'(hi), 32'd21);
        chk1 ("t1_kick_pulse",   exit_loop, 1'b1);
        chk32("t1_kick_cnt",     cycle_cnt, 32'd22);
        step(1);                          // edge 73: RUN
        chk1 ("t1_kick_end", exit_loop, 1'b0);
        chk1 ("t1_run_not_done", done, 1'b0);
        exit_valid = 1'b1;
        exit_value = 32'd0;
        step(1);                          // edge 74: DONE
        exit_valid = 1'b0;
        chk1 ("t1_done",    done,    1'b1);
        chk1 ("t1_pass",    pass,    1'b1);
        chk1 ("t1_fail",    fail,    1'b0);
        chk1 ("t1_timeout", timeout, 1'b0);
        chk32("t1_cnt_frozen", cycle_cnt, 32'd23);
        step(3);
        chk1 ("t1_done_sticky", done, 1'b1);
        chk1 ("t1_core_stays_out", core_rst_n, 1'b1);

        // ---------------- Test 2: flash boot, nonzero exit ----------------
        boot_select = 1'b1;
        exec_flash  = 1'b1;
        rst = 1'b1;
        #1;
        chk1 ("t2_rst_done", done, 1'b0);
        chk1 ("t2_rst_pass", pass, 1'b0);
        rst = 1'b0;
        step(RWC);                        // edge 50: SAMPLE
        chk1 ("t2_release", core_rst_n, 1'b1);
        step(1);                          // edge 51: RUN
        chk1 ("t2_no_load_req",  load_req,      1'b0);
        chk1 ("t2_bootsel_1",    boot_select_q, 1'b1);
        chk1 ("t2_execflash_1",  exec_flash_q,  1'b1);
        chk32("t2_run_cnt",      cycle_cnt,     32'd1);
        exit_valid = 1'b1;
        exit_value = 32'd7;
        step(1);
        exit_valid = 1'b0;
        chk1 ("t2_done",     done,    1'b1);
        chk1 ("t2_fail",     fail,    1'b1);
        chk1 ("t2_pass",     pass,    1'b0);
        chk32("t2_exit_val", exit_value_q, 32'd7);

        // ---------------- Test 3: budget timeout ----------------
        max_cycles = 32'd100;
        exit_value = 32'd0;
        rst = 1'b1;
        #1;
        chk32("t3_rst_exit_val", exit_value_q, 32'd0);
        rst = 1'b0;
        step(RWC);                        // edge 50: SAMPLE, cnt 0
        step(100);                        // edge 150: cnt 100
        chk1 ("t3_not_yet", done, 1'b0);
        chk32("t3_cnt_100", cycle_cnt, 32'd100);
        step(1);                          // edge 151: DONE
        chk1 ("t3_done",     done,    1'b1);
        chk1 ("t3_timeout",  timeout, 1'b1);
        chk1 ("t3_pass",     pass,    1'b0);
        chk32("t3_cnt_frozen", cycle_cnt, 32'd100);
        exit_valid = 1'b1;
        exit_value = 32'd5;
        step(1);
        exit_valid = 1'b0;
        step(2);
        chk1 ("t3_late_exit_timeout", timeout, 1'b1);
        chk1 ("t3_late_exit_fail",    fail,    1'b0);
        chk32("t3_late_exit_val",     exit_value_q, 32'd0);
        chk32("t3_cnt_still",         cycle_cnt,    32'd100);

        // ---------------- Test 4: exit and budget in the same cycle ----------------
        exit_value = 32'd0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step(RWC);                        // edge 50
        step(100);                        // edge 150: cnt 100, budget hits next edge
        exit_valid = 1'b1;
        step(1);                          // edge 151
        exit_valid = 1'b0;
        chk1 ("t4_done",    done,    1'b1);
        chk1 ("t4_pass",    pass,    1'b1);
        chk1 ("t4_timeout", timeout, 1'b0);

        // ---------------- Test 5: reset in the middle of LOAD ----------------
        boot_select = 1'b0;
        exec_flash  = 1'b1;
        max_cycles  = 32'd0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step(RWC + 1);                    // edge 51: LOAD
        chk1 ("t5_in_load", load_req, 1'b1);
        chk1 ("t5_execflash_forced0", exec_flash_q, 1'b0);
        step(5);
        rst = 1'b1;
        #1;                               // no clock edge has occurred
        chk1 ("t5_async_core_rst", core_rst_n, 1'b0);
        chk1 ("t5_async_load_req", load_req,   1'b0);
        chk32("t5_async_cnt",      cycle_cnt,  32'd0);
        rst = 1'b0;
        step(RWC - 1);
        chk1 ("t5_rehold_49", core_rst_n, 1'b0);
        step(1);
        chk1 ("t5_rehold_50", core_rst_n, 1'b1);
        step(1);
        chk1 ("t5_reload_req", load_req, 1'b1);

        // ---------------- Test 6: 4-bit counter saturation ----------------
        s_rst = 1'b0;
        step(4);                          // SAMPLE
        chk1 ("t6_release", s_core_rst_n, 1'b1);
        step(14);                         // 18 edges: cnt 14
        chk32("t6_cnt_14", 32'(s_cycle_cnt), 32'd14);
        step(1);
        chk32("t6_cnt_15", 32'(s_cycle_cnt), 32'd15);
        step(21);                         // 40 edges total
        chk32("t6_cnt_sat", 32'(s_cycle_cnt), 32'd15);
        chk1 ("t6_not_done", s_done, 1'b0);
        chk1 ("t6_no_timeout", s_timeout, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
